// File: rtl/fakeram130_param.sv
// fakeram130_param
//   Single-port, bit-masked SRAM model with configurable geometry. After
//   reset the array is swept to all-zero, one word per cycle; accesses are
//   accepted only once ready_out is high.
//
//   Parameters
//     BITS        data word width (>= 1)
//     WORD_DEPTH  number of words (>= 2, any value)
//     ADDR_WIDTH  address width
//
//   Ports
//     clk           rising-edge clock
//     rst_n         asynchronous active-low reset
//     ce_in         chip enable (accepted when ce_in & ready_out)
//     we_in         1 = write, 0 = read
//     addr_in       word address
//     wd_in         write data
//     w_mask_in     per-bit write enable
//     rd_out        read data, holds until the next read completes
//     rd_valid_out  one-cycle pulse with each completed read
//     ready_out     clear sweep done, accesses accepted
//
//   Build option
//     FAKERAM130_OUT_REG_EN  adds an output register stage (read latency 2).
module fakeram130_param #(
    parameter int BITS       = 95,
    parameter int WORD_DEPTH = 256,
    parameter int ADDR_WIDTH = $clog2(WORD_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce_in,
    input  logic                  we_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [BITS-1:0]       wd_in,
    input  logic [BITS-1:0]       w_mask_in,
    output logic [BITS-1:0]       rd_out,
    output logic                  rd_valid_out,
    output logic                  ready_out
);

`ifdef FAKERAM130_OUT_REG_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;

    logic [BITS-1:0]       r_mem [WORD_DEPTH];

    // vld_pipe[0]: request registered; vld_pipe[STAGES]: data on rd_out
    logic [STAGES:0]       r_vld_pipe;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic                  r_req_ok;
    logic [BITS-1:0]       r_rd_s1;
`ifdef FAKERAM130_OUT_REG_EN
    logic [BITS-1:0]       r_rd_s2;
`endif

    logic w_in_range, w_acc, w_wr, w_rd;

    // A power-of-two depth covers the whole address space.
    if ((2 ** ADDR_WIDTH) == WORD_DEPTH) begin : g_pow2
        assign w_in_range = 1'b1;
    end else begin : g_npow2
        assign w_in_range = ({1'b0, addr_in} < (ADDR_WIDTH + 1)'(WORD_DEPTH));
    end

    assign ready_out = (r_state == S_READY);
    assign w_acc     = ce_in & ready_out;
    assign w_wr      = w_acc & we_in & w_in_range;
    assign w_rd      = w_acc & ~we_in;

    // ---------------- clear sweep FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = S_READY;
                    w_cnt_nxt   = r_cnt;
                end
            end
            S_READY: w_state_nxt = S_READY;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // ---------------- storage ----------------
    // Array contents are never reset; the sweep zeroes them instead.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR)
            r_mem[r_cnt] <= '0;
        else if (w_wr)
            r_mem[addr_in] <= (r_mem[addr_in] & ~w_mask_in) | (wd_in & w_mask_in);
    end

    // ---------------- read pipeline ----------------
    // The array is sampled one edge after acceptance, so a write accepted on
    // the same edge as the sample does not leak into an earlier read, while
    // a write accepted before the read is always visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_req_addr <= '0;
            r_req_ok   <= 1'b0;
            r_rd_s1    <= '0;
`ifdef FAKERAM130_OUT_REG_EN
            r_rd_s2    <= '0;
`endif
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_rd};
            if (w_rd) begin
                r_req_addr <= addr_in;
                r_req_ok   <= w_in_range;
            end
            if (r_vld_pipe[0])
                r_rd_s1 <= r_req_ok ? r_mem[r_req_addr] : '0;
`ifdef FAKERAM130_OUT_REG_EN
            if (r_vld_pipe[1])
                r_rd_s2 <= r_rd_s1;
`endif
        end
    end

`ifdef FAKERAM130_OUT_REG_EN
    assign rd_out = r_rd_s2;
`else
    assign rd_out = r_rd_s1;
`endif
    assign rd_valid_out = r_vld_pipe[STAGES];

endmodule

// File: tb/tb_fakeram130_param.sv
// Self-checking bench for fakeram130_param: a default 95x256 instance driven
// by directed and random traffic against a queue-based reference model, and
// a 16x200 instance for out-of-range addressing.
module tb_fakeram130_param;

    localparam int B  = 95;
    localparam int D  = 256;
    localparam int B1 = 16;
    localparam int D1 = 200;
`ifdef FAKERAM130_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         ce = 1'b0, we = 1'b0;
    logic [7:0]   addr = '0;
    logic [B-1:0] wd = '0, mask = '0;
    logic [B-1:0] rd;
    logic         rv, rdy;

    logic          ce1 = 1'b0, we1 = 1'b0;
    logic [7:0]    addr1 = '0;
    logic [B1-1:0] wd1 = '0, mask1 = '0;
    logic [B1-1:0] rd1;
    logic          rv1, rdy1;

    fakeram130_param dut0 (
        .clk(clk), .rst_n(rst_n), .ce_in(ce), .we_in(we), .addr_in(addr),
        .wd_in(wd), .w_mask_in(mask), .rd_out(rd), .rd_valid_out(rv),
        .ready_out(rdy)
    );

    fakeram130_param #(.BITS(B1), .WORD_DEPTH(D1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ce_in(ce1), .we_in(we1), .addr_in(addr1),
        .wd_in(wd1), .w_mask_in(mask1), .rd_out(rd1), .rd_valid_out(rv1),
        .ready_out(rdy1)
    );

    int checks = 0;
    int errors = 0;

    // reference model: word array plus a queue of reads awaiting delivery
    typedef struct {
        logic [B-1:0] data;
        int           due;
    } exp_t;

    logic [B-1:0] mem_m [D];
    exp_t         q[$];
    logic [B-1:0] exp_rd = '0;
    int           cyc = 0;
    int           edges = 0;
    logic [B-1:0] ones = '1;

    task automatic chkv(input string tag, input logic [B-1:0] obs, input logic [B-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [B-1:0] rand95();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[B-1:0];
    endfunction

    // One clock: update the model from the current drive, pass the edge,
    // then compare all outputs on the falling edge.
    task automatic tick();
        logic acc, ev;
        exp_t e;
        if (!rst_n) begin
            q.delete();
            exp_rd = '0;
            edges  = 0;
            for (int i = 0; i < D; i++) mem_m[i] = '0;
        end else begin
            acc = ce && (edges >= D);
            if (acc && we)
                mem_m[addr] = (mem_m[addr] & ~mask) | (wd & mask);
            if (acc && !we) begin
                e.data = mem_m[addr];
                e.due  = cyc + LAT;
                q.push_back(e);
            end
        end
        @(posedge clk);
        if (rst_n) edges++;
        @(negedge clk);
        ev = (q.size() > 0) && (q[0].due == cyc);
        if (ev) begin
            exp_rd = q[0].data;
            void'(q.pop_front());
        end
        chk1("ready", rdy, edges >= D);
        chk1("rd_valid", rv, ev);
        chkv("rd_out", rd, exp_rd);
        chk1("ready1", rdy1, edges >= D1);
        cyc++;
    endtask

    task automatic acc(input logic w, input logic [7:0] a, input logic [B-1:0] d, input logic [B-1:0] m);
        ce = 1'b1; we = w; addr = a; wd = d; mask = m;
        tick();
        ce = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd1_chk(input string tag, input logic [7:0] a, input logic [B1-1:0] exp);
        ce1 = 1'b1; we1 = 1'b0; addr1 = a;
        tick();
        ce1 = 1'b0;
        idle(LAT);
        chk1({tag, "_valid"}, rv1, 1'b1);
        chkv({tag, "_data"}, B'(rd1), B'(exp));
        tick();
        chk1({tag, "_pulse"}, rv1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < D; i++) mem_m[i] = '0;

        // asynchronous reset values
        #2 rst_n = 1'b0;
        #1;
        chk1("rst_ready", rdy, 1'b0);
        chk1("rst_valid", rv, 1'b0);
        chkv("rst_rd", rd, '0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;

        // sweep, with a write attempt to address 3 that must be ignored
        ce = 1'b1; we = 1'b1; addr = 8'd3; wd = B'(8'h55); mask = ones;
        for (int i = 0; i < D; i++) begin
            if (i == D - 4) ce = 1'b0;
            tick();
        end
        chk1("ready_after_sweep", rdy, 1'b1);

        // swept contents
        acc(1'b0, 8'd0, '0, '0);
        acc(1'b0, 8'd128, '0, '0);
        acc(1'b0, 8'd255, '0, '0);
        acc(1'b0, 8'd3, '0, '0);
        idle(LAT + 1);
        chkv("clear_addr3", rd, '0);

        // masked writes
        acc(1'b1, 8'd5, ones, B'(12'h0F0));
        acc(1'b1, 8'd5, '0, B'(12'h030));
        acc(1'b0, 8'd5, '0, '0);
        idle(LAT);
        chkv("mask_c0", rd, B'(12'h0C0));
        idle(1);

        // streaming
        for (int a = 0; a < 10; a++) acc(1'b1, 8'(a), B'(a + 1), ones);
        for (int a = 0; a < 10; a++) acc(1'b0, 8'(a), '0, '0);
        idle(LAT + 3);
        chkv("stream_hold", rd, B'(10));

        // write then read same address back-to-back
        acc(1'b1, 8'd20, rand95(), rand95());
        acc(1'b0, 8'd20, '0, '0);
        idle(LAT);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            ce   = ($urandom_range(0, 3) != 0);
            we   = $urandom_range(0, 1) == 1;
            addr = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            wd   = rand95();
            mask = ($urandom_range(0, 3) == 0) ? ones : rand95();
            tick();
        end
        ce = 1'b0;
        idle(LAT + 1);

        // out-of-range on the 200-word instance
        ce1 = 1'b1; we1 = 1'b1; mask1 = '1; wd1 = 16'hBEEF;
        addr1 = 8'd210; tick();
        addr1 = 8'd10;  tick();
        ce1 = 1'b0;
        rd1_chk("oor_ref10", 8'd10, 16'hBEEF);
        rd1_chk("oor_210", 8'd210, 16'h0000);
        rd1_chk("oor_200", 8'd200, 16'h0000);
        rd1_chk("oor_199", 8'd199, 16'h0000);

        // reset while a read is in flight
        acc(1'b1, 8'd7, B'(16'h1234), ones);
        acc(1'b0, 8'd7, '0, '0);
        idle(LAT);
        chkv("pre_rst7", rd, B'(16'h1234));
        acc(1'b0, 8'd7, '0, '0);
        rst_n = 1'b0;
        #1;
        chk1("midrst_valid", rv, 1'b0);
        chkv("midrst_rd", rd, '0);
        chk1("midrst_ready", rdy, 1'b0);
        tick();
        rst_n = 1'b1;
        idle(LAT + D);
        chk1("ready_after_resweep", rdy, 1'b1);
        acc(1'b0, 8'd7, '0, '0);
        idle(LAT);
        chkv("post_rst7", rd, '0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
